// File: rtl/sr_pulse_driver_pkg.sv
// Shared types and sizing helpers for the S/R latch pulse driver.
package sr_pulse_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SET  = 2'd1,
    RSTP = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam int DEF_PW_CYCLES  = 3;
  localparam int DEF_GAP_CYCLES = 2;

  // Counter must hold the larger of the two reload values; never narrower than 1 bit.
  function automatic int cnt_width(input int pw, input int gap);
    int m;
    int w;
    m = (pw > gap) ? pw : gap;
    w = $clog2(m + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sr_pulse_driver_if.sv
// Bundle of per-channel request, latch-line and status signals for sr_pulse_driver.
interface sr_pulse_driver_if #(
  parameter int CH = 4
);
  logic [CH-1:0] set_req;
  logic [CH-1:0] rst_req;
  logic [CH-1:0] q_rb;
  logic [CH-1:0] s_n;
  logic [CH-1:0] r_n;
  logic [CH-1:0] busy;
  logic [CH-1:0] done;
  logic [CH-1:0] conflict;
  logic [CH-1:0] q_exp;
  logic [CH-1:0] q_valid;
  logic [CH-1:0] err;

  // Controller/latch side.
  modport master (
    output set_req, rst_req, q_rb,
    input  s_n, r_n, busy, done, conflict, q_exp, q_valid, err
  );

  // Driver side.
  modport slave (
    input  set_req, rst_req, q_rb,
    output s_n, r_n, busy, done, conflict, q_exp, q_valid, err
  );
endinterface

// File: rtl/sr_pulse_driver_chan.sv
// Single-channel pulse FSM: registered active-low pulse, post-pulse gap, expected-level tracking.
// Readback compare is present only when SR_PULSE_DRIVER_READBACK_EN is defined.
module sr_pulse_chan
  import sr_pulse_pkg::*;
#(
  parameter int PW_CYCLES  = DEF_PW_CYCLES,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_set_req,
  input  logic i_rst_req,
  input  logic i_q_rb,
  output logic o_s_n,
  output logic o_r_n,
  output logic o_busy,
  output logic o_done,
  output logic o_conflict,
  output logic o_q_exp,
  output logic o_q_valid,
  output logic o_err
);

  localparam int CW = cnt_width(PW_CYCLES, GAP_CYCLES);

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_s_n, w_s_n_nxt;
  logic            r_r_n, w_r_n_nxt;
  logic            r_done, w_done_nxt;
  logic            r_conflict, w_conflict_nxt;
  logic            r_q_exp, w_q_exp_nxt;
  logic            r_q_valid, w_q_valid_nxt;

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_s_n_nxt      = 1'b1;
    w_r_n_nxt      = 1'b1;
    w_done_nxt     = 1'b0;
    w_conflict_nxt = 1'b0;
    w_q_exp_nxt    = r_q_exp;
    w_q_valid_nxt  = r_q_valid;
    case (r_state)
      IDLE: begin
        if (i_set_req && !i_rst_req) begin
          w_state_nxt = SET;
          w_cnt_nxt   = CW'(PW_CYCLES - 1);
          w_s_n_nxt   = 1'b0;
        end else if (i_rst_req && !i_set_req) begin
          w_state_nxt = RSTP;
          w_cnt_nxt   = CW'(PW_CYCLES - 1);
          w_r_n_nxt   = 1'b0;
        end else if (i_set_req && i_rst_req) begin
          w_conflict_nxt = 1'b1;
        end
      end
      SET, RSTP: begin
        if (r_cnt == '0) begin
          // Both lines released here; the latch has been driven for the full width.
          w_q_exp_nxt   = (r_state == SET);
          w_q_valid_nxt = 1'b1;
          if (GAP_CYCLES > 0) begin
            w_state_nxt = GAP;
            w_cnt_nxt   = CW'(GAP_CYCLES - 1);
          end else begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
          w_s_n_nxt = (r_state != SET);
          w_r_n_nxt = (r_state != RSTP);
        end
      end
      GAP: begin
        if (r_cnt == '0) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_s_n      <= 1'b1;
      r_r_n      <= 1'b1;
      r_done     <= 1'b0;
      r_conflict <= 1'b0;
      r_q_exp    <= 1'b0;
      r_q_valid  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_s_n      <= w_s_n_nxt;
      r_r_n      <= w_r_n_nxt;
      r_done     <= w_done_nxt;
      r_conflict <= w_conflict_nxt;
      r_q_exp    <= w_q_exp_nxt;
      r_q_valid  <= w_q_valid_nxt;
    end
  end

`ifdef SR_PULSE_DRIVER_READBACK_EN
  logic r_err;

  // Compare on the edge that enters IDLE so err is valid in the done cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_done_nxt) begin
      r_err <= (i_q_rb != w_q_exp_nxt);
    end
  end

  assign o_err = r_err;
`else
  logic w_unused_q_rb;
  assign w_unused_q_rb = i_q_rb;
  assign o_err         = 1'b0;
`endif

  assign o_s_n      = r_s_n;
  assign o_r_n      = r_r_n;
  assign o_busy     = (r_state != IDLE);
  assign o_done     = r_done;
  assign o_conflict = r_conflict;
  assign o_q_exp    = r_q_exp;
  assign o_q_valid  = r_q_valid;

endmodule

// File: rtl/sr_pulse_driver.sv
// Multi-channel active-low S/R latch pulse driver; one independent sr_pulse_chan per latch.
// Optional readback checking: define SR_PULSE_DRIVER_READBACK_EN.
module sr_pulse_driver
  import sr_pulse_pkg::*;
#(
  parameter int CH         = 4,
  parameter int PW_CYCLES  = DEF_PW_CYCLES,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input logic               clk,
  input logic               rst,
  sr_pulse_driver_if.slave  io_bus
);

  logic [CH-1:0] w_s_n;
  logic [CH-1:0] w_r_n;
  logic [CH-1:0] w_busy;
  logic [CH-1:0] w_done;
  logic [CH-1:0] w_conflict;
  logic [CH-1:0] w_q_exp;
  logic [CH-1:0] w_q_valid;
  logic [CH-1:0] w_err;

  for (genvar g = 0; g < CH; g++) begin : g_chan
    sr_pulse_chan #(
      .PW_CYCLES  (PW_CYCLES),
      .GAP_CYCLES (GAP_CYCLES)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .i_set_req  (io_bus.set_req[g]),
      .i_rst_req  (io_bus.rst_req[g]),
      .i_q_rb     (io_bus.q_rb[g]),
      .o_s_n      (w_s_n[g]),
      .o_r_n      (w_r_n[g]),
      .o_busy     (w_busy[g]),
      .o_done     (w_done[g]),
      .o_conflict (w_conflict[g]),
      .o_q_exp    (w_q_exp[g]),
      .o_q_valid  (w_q_valid[g]),
      .o_err      (w_err[g])
    );
  end

  assign io_bus.s_n      = w_s_n;
  assign io_bus.r_n      = w_r_n;
  assign io_bus.busy     = w_busy;
  assign io_bus.done     = w_done;
  assign io_bus.conflict = w_conflict;
  assign io_bus.q_exp    = w_q_exp;
  assign io_bus.q_valid  = w_q_valid;
  assign io_bus.err      = w_err;

endmodule

// File: tb/tb_sr_pulse_driver.sv
// Scoreboard bench for sr_pulse_driver: stimulus pushes expected events, a negedge monitor pops and checks them.
module tb_sr_pulse_driver;

  localparam int CH  = 4;
  localparam int PW  = 3;
  localparam int GAP = 2;

  localparam int EV_SP   = 0;  // s_n low run ended: a = width
  localparam int EV_RP   = 1;  // r_n low run ended: a = width
  localparam int EV_DONE = 2;  // a = q_exp, b = q_valid, e = err
  localparam int EV_CONF = 3;  // a = busy, b = s_n & r_n

  typedef struct {
    int kind;
    int ch;
    int cyc;
    int a;
    int b;
    int e;
  } ev_t;

  ev_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  int  cyc   = 0;
  int  s_run[CH];
  int  r_run[CH];

  logic clk = 1'b0;
  logic rst = 1'b1;

  sr_pulse_driver_if #(.CH(CH)) bus ();

  sr_pulse_driver #(
    .CH         (CH),
    .PW_CYCLES  (PW),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int kind, input int ch, input int c, input int a, input int b, input int e);
    ev_t ev;
    ev.kind = kind; ev.ch = ch; ev.cyc = c; ev.a = a; ev.b = b; ev.e = e;
    exp_q.push_back(ev);
  endtask

  task automatic observe(input int kind, input int ch, input int a, input int b, input int e);
    ev_t ev;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected event: got kind %0d ch %0d a %0d at cycle %0d, required none", kind, ch, a, cyc);
    end else begin
      ev = exp_q.pop_front();
      chk($sformatf("ev kind ch%0d", ch), kind, ev.kind);
      chk($sformatf("ev chan k%0d", kind), ch, ev.ch);
      chk($sformatf("ev cycle k%0d ch%0d", kind, ch), cyc, ev.cyc);
      chk($sformatf("ev a k%0d ch%0d", kind, ch), a, ev.a);
      chk($sformatf("ev b k%0d ch%0d", kind, ch), b, ev.b);
      chk($sformatf("ev err k%0d ch%0d", kind, ch), e, ev.e);
    end
  endtask

  // Monitor: invariant plus event extraction on every falling edge.
  initial begin
    for (int i = 0; i < CH; i++) begin
      s_run[i] = 0;
      r_run[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < CH; i++) begin
        chk($sformatf("no s_n&r_n low ch%0d", i), {31'd0, ~bus.s_n[i] & ~bus.r_n[i]}, 32'd0);
        if (bus.s_n[i] === 1'b0) s_run[i]++;
        else if (s_run[i] > 0) begin
          observe(EV_SP, i, s_run[i], 0, 0);
          s_run[i] = 0;
        end
        if (bus.r_n[i] === 1'b0) r_run[i]++;
        else if (r_run[i] > 0) begin
          observe(EV_RP, i, r_run[i], 0, 0);
          r_run[i] = 0;
        end
        if (bus.done[i] === 1'b1)
          observe(EV_DONE, i, int'(bus.q_exp[i]), int'(bus.q_valid[i]), int'(bus.err[i]));
        if (bus.conflict[i] === 1'b1)
          observe(EV_CONF, i, int'(bus.busy[i]), int'(bus.s_n[i] & bus.r_n[i]), 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    int c0;
    int c1;
    int nbusy;

    bus.set_req = '0;
    bus.rst_req = '0;
    bus.q_rb    = '0;
    rst         = 1'b1;
    steps(2);
    rst = 1'b0;
    step();

    // 1: reset state
    chk("reset s_n", bus.s_n, 4'hF);
    chk("reset r_n", bus.r_n, 4'hF);
    chk("reset busy", bus.busy, 4'h0);
    chk("reset done", bus.done, 4'h0);
    chk("reset conflict", bus.conflict, 4'h0);
    chk("reset q_exp", bus.q_exp, 4'h0);
    chk("reset q_valid", bus.q_valid, 4'h0);
    chk("reset err", bus.err, 4'h0);

    // 2: set on ch0, then a dropped request in the done cycle and an accepted one a cycle later
    bus.set_req = 4'b0001;
    step();
    c0 = cyc;
    bus.set_req = '0;
    push(EV_SP, 0, c0 + 3, PW, 0, 0);
    push(EV_DONE, 0, c0 + 5, 1, 1, 0);
    chk("set other busy", bus.busy[3:1], 3'b000);
    nbusy = int'(bus.busy[0]);
    for (int k = 0; k < 4; k++) begin
      step();
      nbusy += int'(bus.busy[0]);
    end
    bus.set_req = 4'b0001;
    step();
    nbusy += int'(bus.busy[0]);
    chk("busy cycles ch0", nbusy, 5);
    step();
    c1 = cyc;
    bus.set_req = '0;
    push(EV_SP, 0, c1 + 3, PW, 0, 0);
    push(EV_DONE, 0, c1 + 5, 1, 1, 0);
    steps(8);

    // 3: simultaneous set/reset on ch1
    bus.set_req = 4'b0010;
    bus.rst_req = 4'b0010;
    step();
    c0 = cyc;
    bus.set_req = '0;
    bus.rst_req = '0;
    push(EV_CONF, 1, c0, 0, 1, 0);
    step();
    chk("conflict one cycle", bus.conflict[1], 1'b0);
    chk("conflict busy", bus.busy[1], 1'b0);
    steps(3);

    // 4: reset pulse on ch2, second request while busy is dropped
    bus.rst_req = 4'b0100;
    step();
    c0 = cyc;
    bus.rst_req = '0;
    push(EV_RP, 2, c0 + 3, PW, 0, 0);
    push(EV_DONE, 2, c0 + 5, 0, 1, 0);
    step();
    bus.rst_req = 4'b0100;
    step();
    bus.rst_req = '0;
    steps(8);
    chk("rstp q_exp ch2", bus.q_exp[2], 1'b0);
    chk("rstp q_valid ch2", bus.q_valid[2], 1'b1);

    // 5: reset during the second pulse cycle of ch3
    bus.set_req = 4'b1000;
    step();
    c0 = cyc;
    bus.set_req = '0;
    step();
    rst = 1'b1;
    push(EV_SP, 3, c0 + 2, 2, 0, 0);
    step();
    chk("rst mid-pulse s_n", bus.s_n, 4'hF);
    rst = 1'b0;
    steps(6);
    chk("rst mid-pulse q_valid", bus.q_valid, 4'h0);
    chk("rst mid-pulse q_exp", bus.q_exp, 4'h0);
    chk("rst mid-pulse busy", bus.busy, 4'h0);

`ifdef SR_PULSE_DRIVER_READBACK_EN
    // 6: readback mismatch sets err, later matching compare clears it
    bus.q_rb = 4'b0000;
    bus.set_req = 4'b0001;
    step();
    c0 = cyc;
    bus.set_req = '0;
    push(EV_SP, 0, c0 + 3, PW, 0, 0);
    push(EV_DONE, 0, c0 + 5, 1, 1, 1);
    steps(8);
    chk("err sticky ch0", bus.err[0], 1'b1);
    bus.q_rb = 4'b0001;
    bus.set_req = 4'b0001;
    step();
    c0 = cyc;
    bus.set_req = '0;
    push(EV_SP, 0, c0 + 3, PW, 0, 0);
    push(EV_DONE, 0, c0 + 5, 1, 1, 0);
    steps(8);
    chk("err cleared ch0", bus.err[0], 1'b0);
`else
    bus.q_rb = 4'b1010;
    bus.set_req = 4'b0001;
    step();
    c0 = cyc;
    bus.set_req = '0;
    push(EV_SP, 0, c0 + 3, PW, 0, 0);
    push(EV_DONE, 0, c0 + 5, 1, 1, 0);
    steps(8);
    chk("err tied low", bus.err, 4'h0);
`endif

    chk("events outstanding", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sr_pulse_driver.md
Name: sr_pulse_driver

Overview:
- Synchronous driver for the active-low S/R latch interface (quad /S-/R latch, one latch per channel); it is the initiator side of that interface.
- Converts single-cycle set/reset requests from clocked logic into clean active-low pulses on s_n/r_n with guaranteed minimum width and inter-pulse gap.
- Never produces the forbidden s_n=r_n=0 combination.
- Placed between a clocked controller and a bank of latch models in board-level benches.

Parameters:
- CH, 4, number of independent channels (one per latch).
- PW_CYCLES, 3, low-pulse width in clk cycles, legal range >=1.
- GAP_CYCLES, 2, minimum cycles with both lines high after a pulse before the next request is accepted, legal range >=0.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- set_req  input  CH  per-channel set request, sampled in IDLE.
- rst_req  input  CH  per-channel reset request, sampled in IDLE.
- s_n  output  CH  active-low set line to latch.
- r_n  output  CH  active-low reset line to latch.
- busy  output  CH  channel is not in IDLE.
- done  output  CH  one-cycle pulse when a channel returns to IDLE after an operation.
- conflict  output  CH  one-cycle pulse when set_req and rst_req arrive together.
- q_exp  output  CH  expected latch level after the last completed operation.
- q_valid  output  CH  q_exp is meaningful (at least one operation done since reset).
- q_rb  input  CH  latch output readback; used only with the optional feature.
- err  output  CH  sticky readback mismatch flag (optional feature).

Behaviour:
- Reset (sync, rst=1 at posedge): all channels go to IDLE. s_n=r_n=all ones; busy=done=conflict=0; q_exp=0; q_valid=0; err=0; counters cleared.
- Reset mid-pulse releases both lines high at the same edge. No done pulse is produced and q_exp is not updated.
- Channels are fully independent. Each channel runs the FSM below.
- IDLE:
  - set_req=1, rst_req=0: go to SET. s_n goes low at the same edge (registered output). Counter loads PW_CYCLES-1.
  - rst_req=1, set_req=0: go to RSTP. r_n goes low in the same way.
  - Both requests =1: stay in IDLE, conflict=1 for one cycle, no line change.
  - Neither request: stay in IDLE.
- SET/RSTP:
  - The line is held low for exactly PW_CYCLES cycles.
  - When the counter reaches 0: both lines go high. q_exp takes 1 (SET) or 0 (RSTP), and q_valid=1.
  - Next state is GAP if GAP_CYCLES>0, otherwise IDLE with done=1.
- GAP: both lines high for exactly GAP_CYCLES cycles, then IDLE with done=1.
- busy=1 in SET, RSTP and GAP.
- Requests arriving while busy=1 are dropped. They are not queued, and conflict is not flagged.
- Minimum request-to-request spacing: PW_CYCLES+GAP_CYCLES+1 cycles. With the default parameters a back-to-back set is accepted 6 cycles after the previous one.
- Repeat set while q_exp=1 is legal and performs a full pulse.
- Invariant checked every cycle: ~s_n[i] & ~r_n[i] == 0.
- Counter width: $clog2(max(PW_CYCLES,GAP_CYCLES)+1), minimum 1 bit.

Optional Feature:
- Macro: SR_PULSE_DRIVER_READBACK_EN.
- Defined:
  - On the cycle a channel enters IDLE from an operation (the done cycle), compare q_rb[i] with q_exp[i].
  - On mismatch, set err[i]. err[i] stays set until rst, or until a later compare on that channel matches.
- Undefined: q_rb is ignored and err is tied to 0. Port list unchanged.

Decomposition:
- Shared package sr_pulse_pkg:
  - State enum {IDLE, SET, RSTP, GAP} (2 bits).
  - Localparam helper for counter width.
- One sub-module, sr_pulse_chan: the single-channel FSM plus counter plus readback compare.
- Top level: generate loop over CH instances with bit-sliced ports.

Test Plan:
1. rst for 2 cycles, then release -> s_n=r_n=4'b1111, q_valid=0, busy=0, err=0.
2. set_req=4'b0001 for 1 cycle -> s_n[0]=0 for exactly 3 cycles. busy[0]=1 for 5 cycles. done[0]=1 on cycle 6. q_exp[0]=1, q_valid[0]=1. Other channels unchanged.
3. set_req[1]=rst_req[1]=1 in IDLE -> conflict[1]=1 for one cycle. s_n[1]=r_n[1]=1 throughout. busy[1]=0.
4. rst_req[2] pulse, then rst_req[2] again 2 cycles later (while busy) -> exactly one 3-cycle r_n[2] low pulse. Second request ignored. q_exp[2]=0.
5. set_req[3], then rst asserted on the 2nd pulse cycle -> s_n[3]=1 at that edge. No done pulse. q_valid[3]=0.
6. With READBACK_EN: set on ch0 with q_rb[0] held 0 -> err[0]=1 on the done cycle. A following set with q_rb[0]=1 clears err[0].
